theatre_cue_sequencer: RTL and testbench

- Operator-console side of the theatre controller interface.
- Accepts mode cues over a valid/ready handshake and performer-position samples. Drives the controller's EN, one-hot House/Music/Speaker/Play lines and active-low TL/TC/TR tracker lines.
- Enforces break-before-make between modes so the controller always sees an all-off gap.
- Rate-limits tracker position changes.

---
 rtl/theatre_cue_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_theatre_cue_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/theatre_cue_sequencer.sv
// theatre_cue_sequencer: operator-console side of the theatre controller.
// Takes mode cues over valid/ready and drives EN, the one-hot mode lines
// House/Music/Speaker/Play and the active-low TL/TC/TR tracker lines.
// Every mode change goes through an all-off gap, and tracker position
// changes are rate-limited by a dwell counter.
// Optional build macro THEATRE_CUE_AUTOCENTER_EN: the tracker starts at
// center on entering Speaker/Play, instead of starting at "none".
//
//   state | meaning
//   IDLE  | enabled, stored mode 0, all lines off
//   GAP   | break-before-make gap, all lines off, no cues accepted
//   DRIVE | one-hot line of the stored mode is high; tracker runs in modes 3/4
`timescale 1ns/1ps

module theatre_cue_sequencer #(
   parameter int GAP_CYC  = 4,
   parameter int HOLD_CYC = 8,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sys_en,
   input  logic       cue_valid,
   output logic       cue_ready,
   input  logic [2:0] cue_mode,
   output logic       cue_err,
   input  logic       pos_valid,
   input  logic [1:0] pos,
   output logic       EN,
   output logic       House,
   output logic       Music,
   output logic       Speaker,
   output logic       Play,
   output logic       TL,
   output logic       TC,
   output logic       TR,
   output logic       busy
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_GAP = 2'd1, S_DRIVE = 2'd2} state_t;

   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [2:0]       TRK_OFF  = 3'b111;

   state_t           r_state, w_state_nxt;
   logic             r_en;
   logic [2:0]       r_mode,    w_mode_nxt;
   logic [3:0]       r_lines,   w_lines_nxt;
   logic [2:0]       r_trk,     w_trk_nxt;
   logic [1:0]       r_pos,     w_pos_nxt;
   logic [CNT_W-1:0] r_gap_cnt, w_gap_nxt;
   logic [CNT_W-1:0] r_dwell,   w_dwell_nxt;
   logic             r_err,     w_err_nxt;

   logic w_kill, w_accept, w_legal, w_change, w_gap_done, w_trk_mode;

   // Mode code to one-hot {House, Music, Speaker, Play}
   function automatic logic [3:0] mode_lines(input logic [2:0] m);
      case (m)
         3'd1:    return 4'b1000;
         3'd2:    return 4'b0100;
         3'd3:    return 4'b0010;
         3'd4:    return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   // Position to active-low {TL, TC, TR}
   function automatic logic [2:0] pos_trk(input logic [1:0] p);
      case (p)
         2'd1:    return 3'b011;
         2'd2:    return 3'b101;
         2'd3:    return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   // A falling sys_en (or the enable register still low) overrides everything else
   assign w_kill     = !sys_en || !r_en;
   assign w_accept   = cue_valid && cue_ready;
   assign w_legal    = (cue_mode <= 3'd4);
   assign w_change   = w_accept && w_legal && (cue_mode != r_mode);
   assign w_gap_done = (r_state == S_GAP) && (r_gap_cnt == '0);
   assign w_trk_mode = (r_mode == 3'd3) || (r_mode == 3'd4);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      if (w_kill) begin
         w_state_nxt = S_IDLE;
      end else if (r_state == S_GAP) begin
         if (w_gap_done) w_state_nxt = (r_mode == 3'd0) ? S_IDLE : S_DRIVE;
      end else if (w_change) begin
         w_state_nxt = S_GAP;
      end
   end

   // Output decode: handshake flags plus next values of the registered outputs
   always_comb begin
      cue_ready   = r_en && (r_state != S_GAP);
      busy        = (r_state == S_GAP);
      w_mode_nxt  = r_mode;
      w_lines_nxt = r_lines;
      w_trk_nxt   = r_trk;
      w_pos_nxt   = r_pos;
      w_gap_nxt   = r_gap_cnt;
      w_dwell_nxt = r_dwell;
      w_err_nxt   = 1'b0;
      if (w_kill) begin
         w_mode_nxt  = 3'd0;
         w_lines_nxt = 4'b0000;
         w_trk_nxt   = TRK_OFF;
         w_pos_nxt   = 2'd0;
         w_gap_nxt   = '0;
         w_dwell_nxt = '0;
      end else if (r_state == S_GAP) begin
         if (!w_gap_done) begin
            w_gap_nxt = r_gap_cnt - CNT_ONE;
         end else begin
            w_lines_nxt = mode_lines(r_mode);
            if (w_trk_mode) begin
`ifdef THEATRE_CUE_AUTOCENTER_EN
               w_pos_nxt   = 2'd2;
               w_trk_nxt   = pos_trk(2'd2);
               w_dwell_nxt = '0;
`else
               w_pos_nxt   = 2'd0;
               w_trk_nxt   = TRK_OFF;
               w_dwell_nxt = HOLD_MAX;
`endif
            end
         end
      end else begin
         w_err_nxt = w_accept && !w_legal;
         if (w_change) begin
            w_mode_nxt  = cue_mode;
            w_lines_nxt = 4'b0000;
            w_trk_nxt   = TRK_OFF;
            w_pos_nxt   = 2'd0;
            w_gap_nxt   = GAP_LOAD;
            w_dwell_nxt = '0;
         end else if ((r_state == S_DRIVE) && w_trk_mode) begin
            if (r_dwell != HOLD_MAX) w_dwell_nxt = r_dwell + CNT_ONE;
            // an accepted cue on the same edge drops the sample
            if (!w_accept && pos_valid && (pos != r_pos) && (r_dwell == HOLD_MAX)) begin
               w_pos_nxt   = pos;
               w_trk_nxt   = pos_trk(pos);
               w_dwell_nxt = '0;
            end
         end
      end
   end

   // Registered outputs and datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_en      <= 1'b0;
         r_mode    <= 3'd0;
         r_lines   <= 4'b0000;
         r_trk     <= TRK_OFF;
         r_pos     <= 2'd0;
         r_gap_cnt <= '0;
         r_dwell   <= '0;
         r_err     <= 1'b0;
      end else begin
         r_en      <= sys_en;
         r_mode    <= w_mode_nxt;
         r_lines   <= w_lines_nxt;
         r_trk     <= w_trk_nxt;
         r_pos     <= w_pos_nxt;
         r_gap_cnt <= w_gap_nxt;
         r_dwell   <= w_dwell_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign EN                          = r_en;
   assign {House, Music, Speaker, Play} = r_lines;
   assign {TL, TC, TR}                = r_trk;
   assign cue_err                     = r_err;

endmodule

// File: tb/tb_theatre_cue_sequencer.sv
// Bench for theatre_cue_sequencer (default build, GAP_CYC=4, HOLD_CYC=8).
// Expected output vectors {EN, H,M,S,P, TL,TC,TR, err, ready, busy} are
// queued as each cycle's stimulus is driven and compared after the edge.
`timescale 1ns/1ps

module tb_theatre_cue_sequencer;

   logic       clk = 1'b0;
   logic       reset, sys_en, cue_valid, pos_valid;
   logic [2:0] cue_mode;
   logic [1:0] pos;
   logic       cue_ready, cue_err, EN, House, Music, Speaker, Play, TL, TC, TR, busy;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      string       tag;
      logic [10:0] v;
   } exp_t;
   exp_t sb_q[$];

   localparam logic [3:0] L_OFF = 4'b0000, L_H = 4'b1000, L_M = 4'b0100,
                          L_S = 4'b0010, L_P = 4'b0001;
   localparam logic [2:0] T_OFF = 3'b111, T_L = 3'b011, T_C = 3'b101, T_R = 3'b110;

   theatre_cue_sequencer #(.GAP_CYC(4), .HOLD_CYC(8), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .sys_en(sys_en), .cue_valid(cue_valid),
      .cue_ready(cue_ready), .cue_mode(cue_mode), .cue_err(cue_err),
      .pos_valid(pos_valid), .pos(pos), .EN(EN), .House(House), .Music(Music),
      .Speaker(Speaker), .Play(Play), .TL(TL), .TC(TC), .TR(TR), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] vec(input logic en, input logic [3:0] l,
                                       input logic [2:0] t, input logic err,
                                       input logic rdy, input logic bsy);
      return {en, l, t, err, rdy, bsy};
   endfunction

   task automatic chk(input string tag, input logic [10:0] act, input logic [10:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got EN,HMSP,LCR,err,rdy,busy=%b expected %b", tag, act, exp);
      else
         n_pass++;
   endtask

   task automatic sb_push(input string tag, input logic [10:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop_check();
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 11'h7ff, 11'h000);
      end else begin
         e = sb_q.pop_front();
         chk(e.tag, {EN, House, Music, Speaker, Play, TL, TC, TR, cue_err, cue_ready, busy}, e.v);
      end
   endtask

   // one clock: queue the expectation, let the edge happen, compare on the falling edge
   task automatic cyc(input string tag, input logic [10:0] v);
      sb_push(tag, v);
      @(posedge clk);
      @(negedge clk);
      sb_pop_check();
   endtask

   task automatic now_chk(input string tag, input logic [10:0] v);
      sb_push(tag, v);
      sb_pop_check();
   endtask

   logic [10:0] v_gap, v_rst, v_idle;

   initial begin
      v_rst  = vec(0, L_OFF, T_OFF, 0, 0, 0);
      v_idle = vec(1, L_OFF, T_OFF, 0, 1, 0);
      v_gap  = vec(1, L_OFF, T_OFF, 0, 0, 1);
      reset = 1'b0; sys_en = 1'b0; cue_valid = 1'b0; cue_mode = 3'd0;
      pos_valid = 1'b0; pos = 2'd0;
      repeat (2) @(negedge clk);
      now_chk("reset_vals", v_rst);

      // 1: release with sys_en high
      reset = 1'b1; sys_en = 1'b1;
      cyc("en_up", v_idle);

      // 2: House, then Music with cue_valid held across the gap
      cue_valid = 1'b1; cue_mode = 3'd1;
      cyc("house_acc", v_gap);
      cue_valid = 1'b0;
      repeat (3) cyc("house_gap", v_gap);
      cyc("house_on", vec(1, L_H, T_OFF, 0, 1, 0));
      cue_valid = 1'b1; cue_mode = 3'd2;
      repeat (4) cyc("music_gap", v_gap);
      cyc("music_on", vec(1, L_M, T_OFF, 0, 1, 0));
      cyc("music_held_same", vec(1, L_M, T_OFF, 0, 1, 0));
      cue_valid = 1'b0;

      // 3: Speaker with tracker rate limiting
      cue_valid = 1'b1; cue_mode = 3'd3;
      cyc("spk_acc", v_gap);
      cue_valid = 1'b0;
      repeat (3) cyc("spk_gap", v_gap);
      cyc("spk_on", vec(1, L_S, T_OFF, 0, 1, 0));
      pos_valid = 1'b1; pos = 2'd1;
      cyc("pos1_first", vec(1, L_S, T_L, 0, 1, 0));
      pos = 2'd2;
      cyc("pos2_early", vec(1, L_S, T_L, 0, 1, 0));
      pos = 2'd3;
      cyc("pos3_early", vec(1, L_S, T_L, 0, 1, 0));
      pos = 2'd2;
      repeat (5) cyc("pos2_dwell", vec(1, L_S, T_L, 0, 1, 0));
      cyc("pos2_sat", vec(1, L_S, T_C, 0, 1, 0));
      pos_valid = 1'b0;
      repeat (8) cyc("spk_hold", vec(1, L_S, T_C, 0, 1, 0));

      // 4: illegal cue together with a position sample, then repeat of current mode
      cue_valid = 1'b1; cue_mode = 3'd6; pos_valid = 1'b1; pos = 2'd1;
      cyc("err_pulse", vec(1, L_S, T_C, 1, 1, 0));
      cue_valid = 1'b0; pos_valid = 1'b0;
      cyc("err_clear", vec(1, L_S, T_C, 0, 1, 0));
      cue_valid = 1'b1; cue_mode = 3'd3;
      cyc("same_mode_nogap", vec(1, L_S, T_C, 0, 1, 0));
      cue_valid = 1'b0; pos_valid = 1'b1; pos = 2'd3;
      cyc("pos3_after", vec(1, L_S, T_R, 0, 1, 0));
      pos_valid = 1'b0;

      // 5: Play at center, then drop sys_en
      cue_valid = 1'b1; cue_mode = 3'd4;
      cyc("play_acc", v_gap);
      cue_valid = 1'b0;
      repeat (3) cyc("play_gap", v_gap);
      cyc("play_on", vec(1, L_P, T_OFF, 0, 1, 0));
      pos_valid = 1'b1; pos = 2'd2;
      cyc("play_center", vec(1, L_P, T_C, 0, 1, 0));
      pos_valid = 1'b0;
      sys_en = 1'b0; cue_valid = 1'b1; cue_mode = 3'd1;
      cyc("en_drop", v_rst);
      cyc("en_off_cue_ign", v_rst);
      sys_en = 1'b1;
      cyc("reenable_idle", v_idle);
      cyc("reenable_cue", v_gap);
      cue_valid = 1'b0;

      // 6: async reset in the middle of the gap
      cyc("mid_gap", v_gap);
      #3 reset = 1'b0;
      #1 now_chk("async_reset", v_rst);
      @(negedge clk);
      reset = 1'b1;
      cyc("post_rst_en", v_idle);
      repeat (5) cyc("post_rst_idle", v_idle);
      cue_valid = 1'b1; cue_mode = 3'd0;
      cyc("post_rst_mode0", v_idle);
      cue_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
